// File: rtl/decode_stage.sv
// decode_stage -- RV64 instruction decode with a registered hand-off to execute.
//
// Decodes R / I-ALU / LD / SD / BEQ, reads the register file asynchronously
// through rf_rs1/rf_rs2, bypasses the writeback port onto the operands and
// holds the decoded entry in one output register until execute accepts it.
// A load-use hazard against the held entry inserts a bubble.
//
// Handshakes (both strict valid/ready):
//   if_valid/id_ready : an instruction transfers on a rising edge where both
//                       are high; upstream keeps if_instr/if_pc stable until then.
//   ex_valid/ex_ready : the held entry leaves on a rising edge where both are
//                       high; until then every ex_* output holds.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   if_valid, if_instr,   upstream instruction and its PC
//   if_pc, id_ready       id_ready = instruction accepted this cycle
//   rf_rs1, rf_rs2        register-file read addresses (combinational)
//   rf_rdata1, rf_rdata2  register-file read data
//   wb_we, wb_rd, wb_data writeback port, bypassed onto the operands
//   ex_ready, flush       execute accepts the entry / kill the entry
//   ex_*                  registered decoded entry for execute
module decode_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_alu_src,
    output logic            ex_mem_to_reg,
    output logic            ex_illegal,
    output logic [1:0]      ex_alu_op
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            alu_src;
        logic            mem_to_reg;
        logic            illegal;
        logic [1:0]      alu_op;
    } entry_t;

    entry_t ex_q;
    entry_t dec;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic       hazard;
    logic       advance;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};

    // Only R, S and B formats actually read rs2; I-type bits [24:20] are
    // immediate bits and must not raise a false load-use stall.
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);

    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == rs1) || ((ex_q.rd == rs2) && uses_rs2));

    assign advance  = !ex_q.valid || ex_ready;
    assign id_ready = !reset && advance && !hazard && !flush;

    // Decode, immediate generation and operand bypass for the incoming word.
    always_comb begin
        dec            = '0;
        dec.valid      = 1'b1;
        dec.pc         = if_pc;
        dec.rs1        = rs1;
        dec.rs2        = rs2;
        dec.rd         = if_instr[11:7];

        // x0 reads as zero; a matching writeback overrides stale RF data.
        if (rs1 == 5'd0)                    dec.op1 = '0;
        else if (wb_we && (wb_rd == rs1))   dec.op1 = wb_data;
        else                                dec.op1 = rf_rdata1;

        if (rs2 == 5'd0)                    dec.op2 = '0;
        else if (wb_we && (wb_rd == rs2))   dec.op2 = wb_data;
        else                                dec.op2 = rf_rdata2;

        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
                dec.imm       = imm_i;
            end
            OP_LD: begin
                if (funct3 == 3'b011) begin
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.imm        = imm_i;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_ST: begin
                if (funct3 == 3'b011) begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.imm       = imm_s;
                    dec.rd        = 5'd0;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_BR: begin
                if (funct3 == 3'b000) begin
                    dec.branch = 1'b1;
                    dec.alu_op = 2'b01;
                    dec.imm    = imm_b;
                    dec.rd     = 5'd0;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Reset beats flush beats load/hold. A bubble clears the whole entry,
    // so stale operands never ride along with ex_valid=0.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_q <= '0;
        end else if (advance) begin
            if (if_valid && id_ready) ex_q <= dec;
            else                      ex_q <= '0;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_op1        = ex_q.op1;
    assign ex_op2        = ex_q.op2;
    assign ex_imm        = ex_q.imm;
    assign ex_rd         = ex_q.rd;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_illegal    = ex_q.illegal;
    assign ex_alu_op     = ex_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed and randomized checks of decode_stage against
// a behavioural model of the decode register.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, if_valid, id_ready, wb_we, ex_ready, flush;
    logic [31:0] if_instr;
    logic [63:0] if_pc, rf_rdata1, rf_rdata2, wb_data;
    logic [4:0]  rf_rs1, rf_rs2, wb_rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic        ex_alu_src, ex_mem_to_reg, ex_illegal;
    logic [63:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [1:0]  ex_alu_op;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_ready(id_ready), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op)
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] pc, op1, op2, imm;
        logic [4:0]  rd, rs1, rs2;
        logic        reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg, illegal;
        logic [1:0]  alu_op;
    } ex_t;

    typedef logic [280:0] wide_t;

    ex_t m;
    ex_t snap;
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic ex_t obs_now();
        ex_t o;
        o = '{ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_rs1, ex_rs2,
              ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src,
              ex_mem_to_reg, ex_illegal, ex_alu_op};
        return o;
    endfunction

    // Two's-complement interpretation of an unsigned bit-field value.
    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic logic [63:0] ref_operand(input logic [4:0] rs, input logic [63:0] rdata);
        if (rs == 5'd0) return 64'd0;
        if (wb_we && wb_rd == rs) return wb_data;
        return rdata;
    endfunction

    function automatic ex_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                       input logic [63:0] op1, input logic [63:0] op2);
        ex_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        e = '0;
        opc = ins[6:0];
        f3 = ins[14:12];
        e.valid = 1'b1;
        e.pc = pc;
        e.op1 = op1;
        e.op2 = op2;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        if (opc == 7'h33) begin
            e.reg_write = 1'b1; e.alu_op = 2'd2;
        end else if (opc == 7'h13) begin
            e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_op = 2'd2;
            e.imm = sext(longint'(ins[31:20]), 12);
        end else if (opc == 7'h03 && f3 == 3'd3) begin
            e.reg_write = 1'b1; e.mem_read = 1'b1; e.alu_src = 1'b1; e.mem_to_reg = 1'b1;
            e.imm = sext(longint'(ins[31:20]), 12);
        end else if (opc == 7'h23 && f3 == 3'd3) begin
            e.mem_write = 1'b1; e.alu_src = 1'b1; e.rd = 5'd0;
            e.imm = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
        end else if (opc == 7'h63 && f3 == 3'd0) begin
            e.branch = 1'b1; e.alu_op = 2'd1; e.rd = 5'd0;
            e.imm = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                         longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance the model, check the register.
    task automatic tick(input string tag);
        logic       haz, exp_ready;
        logic [4:0] s1, s2;
        logic [6:0] opc;
        ex_t        nxt;
        #1;
        s1  = if_instr[19:15];
        s2  = if_instr[24:20];
        opc = if_instr[6:0];
        haz = m.valid && m.mem_read && m.rd != 5'd0 &&
              (m.rd == s1 || (m.rd == s2 && (opc == 7'h33 || opc == 7'h23 || opc == 7'h63)));
        exp_ready = !reset && (!m.valid || ex_ready) && !haz && !flush;
        chk({tag, ".id_ready"}, wide_t'(id_ready), wide_t'(exp_ready));
        chk({tag, ".rf_rs"}, wide_t'({rf_rs1, rf_rs2}), wide_t'({s1, s2}));
        if (reset || flush) nxt = '0;
        else if (!m.valid || ex_ready)
            nxt = (if_valid && exp_ready) ?
                  ref_decode(if_instr, if_pc, ref_operand(s1, rf_rdata1), ref_operand(s2, rf_rdata2)) : '0;
        else nxt = m;
        @(posedge clk);
        m = nxt;
        #1;
        chk({tag, ".ex"}, wide_t'(obs_now()), wide_t'(m));
        @(negedge clk);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        return {7'd0, s2, s1, 3'd0, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] s1, input logic [11:0] imm);
        return {imm, s1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, s1, s2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  opc;
        rd  = 5'($urandom_range(0, 7));
        s1  = 5'($urandom_range(0, 7));
        s2  = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        f3  = 3'($urandom);
        case ($urandom_range(0, 6))
            0: return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, s2, s1, f3, rd, 7'h33};
            1: return enc_i(7'h13, f3, rd, s1, imm);
            2: return enc_i(7'h03, 3'd3, rd, s1, imm);
            3: return {imm[11:5], s2, s1, 3'd3, imm[4:0], 7'h23};
            4: return {imm[11:5], s2, s1, 3'd0, imm[4:0], 7'h63};
            5: return enc_i(7'h03, 3'd2, rd, s1, imm);
            default: begin
                opc = 7'($urandom);
                while (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 || opc == 7'h63)
                    opc = 7'($urandom);
                return {imm, s1, f3, rd, opc};
            end
        endcase
    endfunction

    initial begin
        m = '0;
        reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 64'd0;
        rf_rdata1 = 64'd0; rf_rdata2 = 64'd0; wb_we = 1'b0; wb_rd = 5'd0;
        wb_data = 64'd0; ex_ready = 1'b1; flush = 1'b0;

        // Reset state
        tick("rst0");
        tick("rst1");
        chk("rst.valid", wide_t'(ex_valid), wide_t'(1'b0));
        reset = 1'b0;

        // add x3,x1,x2
        if_valid = 1'b1; if_instr = enc_r(5'd3, 5'd1, 5'd2); if_pc = 64'h1000;
        rf_rdata1 = 64'd5; rf_rdata2 = 64'd7;
        tick("add");
        chk("add.valid", wide_t'(ex_valid), wide_t'(1'b1));
        chk("add.op1", wide_t'(ex_op1), wide_t'(64'd5));
        chk("add.op2", wide_t'(ex_op2), wide_t'(64'd7));
        chk("add.rd", wide_t'(ex_rd), wide_t'(5'd3));
        chk("add.ctl", wide_t'({ex_reg_write, ex_alu_op}), wide_t'(3'b110));

        // ld x5,8(x1) then dependent add x6,x5,x2
        if_instr = enc_i(7'h03, 3'd3, 5'd5, 5'd1, 12'd8); if_pc = 64'h1004;
        tick("ld");
        if_instr = enc_r(5'd6, 5'd5, 5'd2); if_pc = 64'h1008;
        #1;
        chk("luse.id_ready", wide_t'(id_ready), wide_t'(1'b0));
        tick("luse_stall");
        chk("luse.bubble", wide_t'(ex_valid), wide_t'(1'b0));
        tick("luse_go");
        chk("luse.accept", wide_t'({ex_valid, ex_rd}), wide_t'({1'b1, 5'd6}));

        // Writeback bypass onto rs1
        if_instr = enc_r(5'd7, 5'd1, 5'd4); rf_rdata1 = 64'h11;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 64'hAA;
        tick("byp");
        chk("byp.op1", wide_t'(ex_op1), wide_t'(64'hAA));
        wb_we = 1'b0;

        // beq with imm=-4
        if_instr = 32'hFE000EE3;
        tick("beq");
        chk("beq.imm", wide_t'(ex_imm), wide_t'(64'hFFFF_FFFF_FFFF_FFFC));
        chk("beq.rd_br", wide_t'({ex_rd, ex_branch}), wide_t'({5'd0, 1'b1}));

        // Stall three cycles, flush in the second
        if_instr = enc_i(7'h13, 3'd0, 5'd9, 5'd2, 12'h123);
        tick("st_load");
        snap = obs_now();
        ex_ready = 1'b0; if_instr = enc_r(5'd10, 5'd1, 5'd2);
        #1;
        chk("st.id_ready", wide_t'(id_ready), wide_t'(1'b0));
        tick("st_c1");
        chk("st.stable", wide_t'(obs_now()), wide_t'(snap));
        flush = 1'b1;
        tick("st_c2");
        chk("st.flush", wide_t'(ex_valid), wide_t'(1'b0));
        flush = 1'b0;
        tick("st_c3");

        // Illegal opcode, then reset while stalled
        ex_ready = 1'b1; if_instr = 32'h0000_007F;
        tick("ill");
        chk("ill.ctl", wide_t'({ex_valid, ex_illegal, ex_reg_write}), wide_t'(3'b110));
        ex_ready = 1'b0; if_instr = enc_r(5'd2, 5'd3, 5'd4); reset = 1'b1;
        tick("rst_mid");
        chk("rst_mid.all", wide_t'(obs_now()), wide_t'(0));
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 5);
            if_valid  = ($urandom_range(0, 3) != 0);
            ex_ready  = ($urandom_range(0, 9) < 7);
            if_instr  = rand_instr();
            if_pc     = {32'd0, $urandom} & 64'hFFFF_FFFC;
            rf_rdata1 = {$urandom, $urandom};
            rf_rdata2 = {$urandom, $urandom};
            wb_we     = ($urandom_range(0, 1) == 1);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = {$urandom, $urandom};
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
